mdu_div: RTL and testbench

Iterative 32-bit signed/unsigned divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage directly downstream of the register file. It takes the two read-port operands (rs1 → dividend, rs2 → divisor) plus the destination register index. It returns the result and index for the register-file write port (write data / write select) over a valid/ready handshake. It processes one division at a time using a restoring-division state machine, one quotient bit per clock.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_div_if.sv | 24 ++
 rtl/mdu_div_step.sv | 17 +
 rtl/mdu_div.sv | 99 +++++++++
 tb/tb_mdu_div.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package mdu_pkg;

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } funct3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_if.sv
// Request/response bundle between the register-file read ports, the divider and write-back.
interface mdu_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        busy;

  modport master (
    output in_valid, funct3, op_a, op_b, rd_i, out_ready,
    input  in_ready, out_valid, result_o, rd_o, busy
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, rd_i, out_ready,
    output in_ready, out_valid, result_o, rd_o, busy
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step (
  input  logic [32:0] rem,
  input  logic        q_msb,
  input  logic [31:0] dvs,
  output logic [32:0] rem_next,
  output logic        q_bit
);
  logic [33:0] trial;

  // Carrying the full remainder keeps the borrow bit honest even though rem[32] is always 0 here.
  always_comb begin
    trial    = {rem, q_msb} - {2'b00, dvs};
    q_bit    = ~trial[33];
    rem_next = q_bit ? trial[32:0] : {rem[31:0], q_msb};
  end
endmodule

// File: rtl/mdu_div.sv
// Iterative 32-bit DIV/DIVU/REM/REMU, one quotient bit per clock; 34-cycle latency, 1 for x/0 and INT_MIN/-1.
// Single operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  mdu_div_if.slave    bus
);
  div_state_t  state, state_nxt;
  logic [4:0]  count;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic        is_rem, neg_q, neg_r;

  logic        sgn_op, rem_op, accept, div_zero, ovf;
  logic [32:0] rem_next;
  logic        q_bit;

  always_comb begin
    sgn_op   = (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    rem_op   = (bus.funct3 == F3_REM) || (bus.funct3 == F3_REMU);
    accept   = bus.in_valid && (state == S_IDLE) && !flush;
    div_zero = (bus.op_b == 32'd0);
    ovf      = sgn_op && (bus.op_a == INT_MIN) && (bus.op_b == ALL_ONES);
  end

  div_step u_step (
    .rem      (rem),
    .q_msb    (quo[31]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (div_zero || ovf) ? S_DONE : S_DIV;
      S_DIV:   if (count == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      result_q <= '0;
      rd_q     <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          rd_q   <= bus.rd_i;
          is_rem <= rem_op;
          neg_q  <= sgn_op && (bus.op_a[31] ^ bus.op_b[31]);
          neg_r  <= sgn_op && bus.op_a[31];
          // Q starts as |dividend| so its msb feeds the remainder on each step.
          quo    <= neg_if(bus.op_a, sgn_op && bus.op_a[31]);
          dvs    <= neg_if(bus.op_b, sgn_op && bus.op_b[31]);
          rem    <= '0;
          count  <= '0;
          if (div_zero)  result_q <= rem_op ? bus.op_a : ALL_ONES;
          else if (ovf)  result_q <= rem_op ? 32'd0 : INT_MIN;
        end
        S_DIV: begin
          rem   <= rem_next;
          quo   <= {quo[30:0], q_bit};
          count <= count + 5'd1;
        end
        S_FIX: result_q <= is_rem ? neg_if(rem[31:0], neg_r) : neg_if(quo, neg_q);
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.result_o  = result_q;
  assign bus.rd_o      = rd_q;
endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for mdu_div: arithmetic, fast paths, stall, flush and reset abort.
module tb_mdu_div;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   fails  = 0;

  mdu_div_if bus();

  mdu_div dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called at a negedge; presents the request across exactly one rising edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd_i     = rd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.funct3   = 3'b000;
    bus.rd_i     = 5'd31;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic retire;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.result_o !== 32'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    checks++; if (bus.rd_o !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d expected 0", bus.rd_o); end
  endtask

  task automatic test_signed;
    int cyc;
    issue(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd3);
    wait_valid(cyc);
    checks++; if (cyc !== 33) begin fails++; $display("FAIL div_7_m2_latency: got %0d expected 33", cyc); end
    checks++; if (bus.result_o !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_7_m2: got %h expected fffffffd", bus.result_o); end
    checks++; if (bus.rd_o !== 5'd3) begin fails++; $display("FAIL div_7_m2_rd: got %0d expected 3", bus.rd_o); end
    retire();
    issue(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd4);
    wait_valid(cyc);
    checks++; if (cyc !== 33) begin fails++; $display("FAIL rem_7_m2_latency: got %0d expected 33", cyc); end
    checks++; if (bus.result_o !== 32'd1) begin fails++; $display("FAIL rem_7_m2: got %h expected 1", bus.result_o); end
    retire();
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_valid(cyc);
    checks++; if (bus.result_o !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_m7_2: got %h expected fffffffd", bus.result_o); end
    retire();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_valid(cyc);
    checks++; if (bus.result_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_m7_2: got %h expected ffffffff", bus.result_o); end
    retire();
  endtask

  task automatic test_unsigned;
    int cyc;
    issue(3'b101, 32'hFFFF_FFFF, 32'd3, 5'd7);
    wait_valid(cyc);
    checks++; if (bus.result_o !== 32'h5555_5555) begin fails++; $display("FAIL divu_max_3: got %h expected 55555555", bus.result_o); end
    retire();
    issue(3'b111, 32'd100, 32'd7, 5'd8);
    wait_valid(cyc);
    checks++; if (bus.result_o !== 32'd2) begin fails++; $display("FAIL remu_100_7: got %h expected 2", bus.result_o); end
    retire();
    issue(3'b011, 32'd100, 32'd7, 5'd9);
    wait_valid(cyc);
    checks++; if (bus.result_o !== 32'd14) begin fails++; $display("FAIL illegal_as_divu: got %h expected e", bus.result_o); end
    retire();
  endtask

  task automatic test_special;
    int cyc;
    issue(3'b100, 32'd55, 32'd0, 5'd10);
    wait_valid(cyc);
    checks++; if (cyc !== 0) begin fails++; $display("FAIL div0_latency: got %0d expected 0", cyc); end
    checks++; if (bus.result_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_by_0: got %h expected ffffffff", bus.result_o); end
    retire();
    issue(3'b110, 32'h0000_1234, 32'd0, 5'd11);
    wait_valid(cyc);
    checks++; if (cyc !== 0) begin fails++; $display("FAIL rem0_latency: got %0d expected 0", cyc); end
    checks++; if (bus.result_o !== 32'h0000_1234) begin fails++; $display("FAIL rem_by_0: got %h expected 1234", bus.result_o); end
    retire();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    wait_valid(cyc);
    checks++; if (cyc !== 0) begin fails++; $display("FAIL ovf_div_latency: got %0d expected 0", cyc); end
    checks++; if (bus.result_o !== 32'h8000_0000) begin fails++; $display("FAIL ovf_div: got %h expected 80000000", bus.result_o); end
    retire();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    wait_valid(cyc);
    checks++; if (cyc !== 0) begin fails++; $display("FAIL ovf_rem_latency: got %0d expected 0", cyc); end
    checks++; if (bus.result_o !== 32'd0) begin fails++; $display("FAIL ovf_rem: got %h expected 0", bus.result_o); end
    retire();
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(3'b101, 32'd20, 32'd3, 5'd5);
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.result_o !== 32'd6 || bus.rd_o !== 5'd5 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got res=%h rd=%0d in_ready=%b out_valid=%b expected 6/5/0/1",
                 i, bus.result_o, bus.rd_o, bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
    end
    retire();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL after_retire: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
    issue(3'b101, 32'd99, 32'd9, 5'd14);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL next_accept: got busy=%b expected 1", bus.busy); end
    wait_valid(cyc);
    checks++; if (bus.result_o !== 32'd11 || bus.rd_o !== 5'd14) begin fails++; $display("FAIL next_result: got %h rd %0d expected b rd 14", bus.result_o, bus.rd_o); end
    retire();
  endtask

  task automatic test_abort;
    int cyc;
    int saw_valid;
    bus.in_valid = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd9; bus.op_b = 32'd2; flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_blocks_accept: got busy=%b expected 0", bus.busy); end

    saw_valid = 0;
    issue(3'b100, 32'd1000, 32'd7, 5'd15);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw_valid++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_idle: got busy=%b in_ready=%b expected 0/1", bus.busy, bus.in_ready); end

    issue(3'b100, 32'd1000, 32'd7, 5'd16);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw_valid++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_idle: got busy=%b in_ready=%b expected 0/1", bus.busy, bus.in_ready); end
    checks++; if (bus.result_o !== 32'd0 || bus.rd_o !== 5'd0) begin fails++; $display("FAIL rst_clears: got %h rd %0d expected 0 rd 0", bus.result_o, bus.rd_o); end
    checks++; if (saw_valid !== 0) begin fails++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", saw_valid); end

    issue(3'b101, 32'd100, 32'd7, 5'd17);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL post_abort_accept: got busy=%b expected 1", bus.busy); end
    wait_valid(cyc);
    checks++; if (cyc !== 33) begin fails++; $display("FAIL post_abort_latency: got %0d expected 33", cyc); end
    checks++; if (bus.result_o !== 32'd14 || bus.rd_o !== 5'd17) begin fails++; $display("FAIL post_abort_result: got %h rd %0d expected e rd 17", bus.result_o, bus.rd_o); end
    retire();
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'b000;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.rd_i      = 5'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
